// File: rtl/rx_cmd_pkg.sv
// ----------------------------------------------------------------------------
// rx_cmd_pkg : event codes, ASCII constants, FSM states, byte classifier   rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rx_cmd_pkg;

  localparam logic [2:0] EV_NONE   = 3'd0;
  localparam logic [2:0] EV_Q25    = 3'd1;
  localparam logic [2:0] EV_D10    = 3'd2;
  localparam logic [2:0] EV_SEL    = 3'd3;
  localparam logic [2:0] EV_CANCEL = 3'd4;
  localparam logic [2:0] EV_ERR    = 3'd5;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_9  = 8'h39;
  localparam logic [7:0] ASC_Q  = 8'h51;
  localparam logic [7:0] ASC_D  = 8'h44;
  localparam logic [7:0] ASC_S  = 8'h53;
  localparam logic [7:0] ASC_C  = 8'h43;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ENTRY = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    CL_BAD    = 3'd0,
    CL_DIGIT  = 3'd1,
    CL_Q25    = 3'd2,
    CL_D10    = 3'd3,
    CL_SEL    = 3'd4,
    CL_CANCEL = 3'd5,
    CL_WS     = 3'd6
  } byte_class_t;

  function automatic byte_class_t classify(input logic [7:0] b, input logic fold);
    logic [7:0]  u;
    byte_class_t c;
    u = b;
    // Only the four command letters fold; every other lowercase byte stays BAD.
    if (fold && (b == 8'h71 || b == 8'h64 || b == 8'h73 || b == 8'h63))
      u = b & 8'hDF;
    if (u >= ASC_0 && u <= ASC_9)                      c = CL_DIGIT;
    else if (u == ASC_Q)                               c = CL_Q25;
    else if (u == ASC_D)                               c = CL_D10;
    else if (u == ASC_S)                               c = CL_SEL;
    else if (u == ASC_C)                               c = CL_CANCEL;
    else if (u == ASC_SP || u == ASC_CR || u == ASC_LF) c = CL_WS;
    else                                               c = CL_BAD;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_evt_fifo.sv
// ----------------------------------------------------------------------------
// rx_evt_fifo : synchronous event FIFO, power-of-two depth, zero head when empty   rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rx_evt_fifo #(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rx_cmd_parser.sv
// ----------------------------------------------------------------------------
// rx_cmd_parser : UART command decoder with multi-digit item entry and event FIFO   rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rx_cmd_parser
  import rx_cmd_pkg::*;
#(
  parameter  int MAX_ITEM   = 7,
  parameter  int FIFO_DEPTH = 4,
  parameter  int CASE_FOLD  = 1,
  localparam int ITEM_W     = $clog2(MAX_ITEM + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  input  logic              ev_ready,
  input  logic              ovf_clr,
  output logic              ev_valid,
  output logic [2:0]        ev_type,
  output logic [ITEM_W-1:0] ev_item,
  output logic [ITEM_W-1:0] item_pend,
  output logic              entry_act,
  output logic [7:0]        dout,
  output logic              echo_pulse,
  output logic              ovf
);

  localparam int ACC_W  = ITEM_W + 4;
  localparam int FIFO_W = 3 + ITEM_W;
  localparam int MUL_W  = ACC_W + 4;

  state_t              state;
  state_t              state_nx;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_nx;
  byte_class_t         cls;
  logic [3:0]          digit;
  logic [MUL_W-1:0]    acc_mul;
  logic                push_req;
  logic [2:0]          push_type;
  logic [ITEM_W-1:0]   push_item;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                drop;
  logic [FIFO_W-1:0]   head;

  assign cls     = classify(rx_byte, CASE_FOLD != 0);
  assign digit   = rx_byte[3:0];
  // Widened so an out-of-range entry is caught before truncation to ITEM_W.
  assign acc_mul = (MUL_W'(acc) * MUL_W'(10)) + MUL_W'(digit);

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    push_req  = 1'b0;
    push_type = EV_NONE;
    push_item = '0;
    if (rx_dv) begin
      case (state)
        ST_IDLE: begin
          case (cls)
            CL_DIGIT: begin
              acc_nx   = ACC_W'(digit);
              state_nx = ST_ENTRY;
            end
            CL_Q25:    begin push_req = 1'b1; push_type = EV_Q25;    end
            CL_D10:    begin push_req = 1'b1; push_type = EV_D10;    end
            CL_SEL:    begin push_req = 1'b1; push_type = EV_ERR;    end
            CL_CANCEL: begin push_req = 1'b1; push_type = EV_CANCEL; end
            CL_WS:     ;
            default:   begin push_req = 1'b1; push_type = EV_ERR;    end
          endcase
        end
        ST_ENTRY: begin
          case (cls)
            CL_DIGIT: begin
              if (acc_mul > MUL_W'(MAX_ITEM)) begin
                push_req  = 1'b1;
                push_type = EV_ERR;
                acc_nx    = '0;
                state_nx  = ST_IDLE;
              end else begin
                acc_nx = acc_mul[ACC_W-1:0];
              end
            end
            CL_SEL: begin
              push_req  = 1'b1;
              push_type = EV_SEL;
              push_item = acc[ITEM_W-1:0];
              acc_nx    = '0;
              state_nx  = ST_IDLE;
            end
            CL_CANCEL: begin
              push_req  = 1'b1;
              push_type = EV_CANCEL;
              acc_nx    = '0;
              state_nx  = ST_IDLE;
            end
            CL_Q25:  begin push_req = 1'b1; push_type = EV_Q25; end
            CL_D10:  begin push_req = 1'b1; push_type = EV_D10; end
            CL_WS:   ;
            default: begin
              push_req  = 1'b1;
              push_type = EV_ERR;
              acc_nx    = '0;
              state_nx  = ST_IDLE;
            end
          endcase
        end
        default: begin
          state_nx = ST_IDLE;
          acc_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      acc   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      echo_pulse <= 1'b0;
    end else begin
      echo_pulse <= rx_dv;
      if (rx_dv)
        dout <= rx_byte;
    end
  end

  assign pop  = ev_valid && ev_ready;
  assign drop = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovf <= 1'b0;
    else if (drop)
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end

  rx_evt_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .din     ({push_type, push_item}),
    .pop     (pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ev_valid  = !fifo_empty;
  assign ev_type   = head[FIFO_W-1:ITEM_W];
  assign ev_item   = head[ITEM_W-1:0];
  assign item_pend = acc[ITEM_W-1:0];
  assign entry_act = (state == ST_ENTRY);

endmodule

`default_nettype wire

// File: tb/tb_rx_cmd_parser.sv
// ----------------------------------------------------------------------------
// tb_rx_cmd_parser : directed self-checking bench, default and MAX_ITEM=12/no-fold instances   rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rx_cmd_parser;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       rx_dv_a, ev_ready_a, ovf_clr_a;
  logic [7:0] rx_byte_a;
  logic       ev_valid_a, entry_act_a, echo_pulse_a, ovf_a;
  logic [2:0] ev_type_a;
  logic [2:0] ev_item_a, item_pend_a;
  logic [7:0] dout_a;

  logic       rx_dv_b, ev_ready_b, ovf_clr_b;
  logic [7:0] rx_byte_b;
  logic       ev_valid_b, entry_act_b, echo_pulse_b, ovf_b;
  logic [2:0] ev_type_b;
  logic [3:0] ev_item_b, item_pend_b;
  logic [7:0] dout_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rx_cmd_parser #(.MAX_ITEM(7), .FIFO_DEPTH(4), .CASE_FOLD(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv_a), .rx_byte(rx_byte_a),
    .ev_ready(ev_ready_a), .ovf_clr(ovf_clr_a), .ev_valid(ev_valid_a),
    .ev_type(ev_type_a), .ev_item(ev_item_a), .item_pend(item_pend_a),
    .entry_act(entry_act_a), .dout(dout_a), .echo_pulse(echo_pulse_a), .ovf(ovf_a)
  );

  rx_cmd_parser #(.MAX_ITEM(12), .FIFO_DEPTH(4), .CASE_FOLD(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv_b), .rx_byte(rx_byte_b),
    .ev_ready(ev_ready_b), .ovf_clr(ovf_clr_b), .ev_valid(ev_valid_b),
    .ev_type(ev_type_b), .ev_item(ev_item_b), .item_pend(item_pend_b),
    .entry_act(entry_act_b), .dout(dout_b), .echo_pulse(echo_pulse_b), .ovf(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; byte is captured at the next posedge, returns at the following negedge.
  task automatic send(input bit b_sel, input logic [7:0] val);
    if (b_sel) begin rx_dv_b = 1'b1; rx_byte_b = val; end
    else       begin rx_dv_a = 1'b1; rx_byte_a = val; end
    @(negedge clk);
    rx_dv_a = 1'b0;
    rx_dv_b = 1'b0;
  endtask

  task automatic pop_chk(input bit b_sel, input string tag, input logic [2:0] typ, input logic [3:0] item);
    if (b_sel) begin
      chk({tag, "_valid"}, ev_valid_b, 1);
      chk({tag, "_type"},  ev_type_b,  typ);
      chk({tag, "_item"},  ev_item_b,  item);
      ev_ready_b = 1'b1;
    end else begin
      chk({tag, "_valid"}, ev_valid_a, 1);
      chk({tag, "_type"},  ev_type_a,  typ);
      chk({tag, "_item"},  ev_item_a,  item);
      ev_ready_a = 1'b1;
    end
    @(negedge clk);
    ev_ready_a = 1'b0;
    ev_ready_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    rx_dv_a = 0; rx_byte_a = 0; ev_ready_a = 0; ovf_clr_a = 0;
    rx_dv_b = 0; rx_byte_b = 0; ev_ready_b = 0; ovf_clr_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", ev_valid_a, 0);
    chk("rst_entry", entry_act_a, 0);
    chk("rst_pend",  item_pend_a, 0);
    chk("rst_ovf",   ovf_a, 0);
    chk("rst_dout",  dout_a, 0);
    chk("rst_echo",  echo_pulse_a, 0);
    chk("rst_type",  ev_type_a, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Mid-operation reset discards a queued event and a pending digit
    send(0, 8'h51);
    send(0, 8'h35);
    chk("t1_pre_entry", entry_act_a, 1);
    chk("t1_pre_pend",  item_pend_a, 5);
    chk("t1_pre_valid", ev_valid_a, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_valid", ev_valid_a, 0);
    chk("t1_entry", entry_act_a, 0);
    chk("t1_pend",  item_pend_a, 0);
    chk("t1_ovf",   ovf_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // "3","S" with consumer ready
    ev_ready_a = 1'b1;
    send(0, 8'h33);
    chk("t2_echo1", echo_pulse_a, 1);
    chk("t2_dout1", dout_a, 8'h33);
    chk("t2_pend",  item_pend_a, 3);
    chk("t2_nov",   ev_valid_a, 0);
    send(0, 8'h53);
    chk("t2_echo2", echo_pulse_a, 1);
    chk("t2_dout2", dout_a, 8'h53);
    chk("t2_valid", ev_valid_a, 1);
    chk("t2_type",  ev_type_a, 3);
    chk("t2_item",  ev_item_a, 3);
    chk("t2_idle",  entry_act_a, 0);
    @(negedge clk);
    chk("t2_popped", ev_valid_a, 0);
    chk("t2_echo0",  echo_pulse_a, 0);
    ev_ready_a = 1'b0;

    // Coins mid-entry keep ENTRY; lowercase 'd' folds
    send(0, 8'h34);
    send(0, 8'h51);
    chk("t4_entry_q", entry_act_a, 1);
    chk("t4_pend_q",  item_pend_a, 4);
    send(0, 8'h64);
    chk("t4_entry_d", entry_act_a, 1);
    send(0, 8'h53);
    chk("t4_idle", entry_act_a, 0);
    pop_chk(0, "t4_ev0", 3'd1, 4'd0);
    pop_chk(0, "t4_ev1", 3'd2, 4'd0);
    pop_chk(0, "t4_ev2", 3'd3, 4'd4);
    chk("t4_empty", ev_valid_a, 0);

    // 'S' in IDLE, cancel, out-of-range entry, bad byte, folded 's'
    send(0, 8'h53);
    pop_chk(0, "t6_selidle", 3'd5, 4'd0);
    send(0, 8'h37);
    send(0, 8'h43);
    chk("t6_cpend",  item_pend_a, 0);
    chk("t6_centry", entry_act_a, 0);
    pop_chk(0, "t6_cancel", 3'd4, 4'd0);
    send(0, 8'h37);
    send(0, 8'h38);
    chk("t6_range_entry", entry_act_a, 0);
    pop_chk(0, "t6_range", 3'd5, 4'd0);
    send(0, 8'h78);
    pop_chk(0, "t6_bad", 3'd5, 4'd0);
    send(0, 8'h36);
    send(0, 8'h73);
    pop_chk(0, "t6_fold", 3'd3, 4'd6);
    send(0, 8'h20);
    chk("t6_sp_echo",  echo_pulse_a, 1);
    chk("t6_sp_dout",  dout_a, 8'h20);
    chk("t6_sp_valid", ev_valid_a, 0);
    send(0, 8'h0D);
    chk("t6_cr_dout",  dout_a, 8'h0D);
    chk("t6_cr_valid", ev_valid_a, 0);
    chk("t6_cr_entry", entry_act_a, 0);
    @(negedge clk);
    chk("t6_echo_off", echo_pulse_a, 0);

    // Overflow: fifth push on full FIFO drops
    repeat (4) send(0, 8'h51);
    chk("t5_full_ovf", ovf_a, 0);
    send(0, 8'h51);
    chk("t5_drop_ovf", ovf_a, 1);
    for (int i = 0; i < 4; i++) pop_chk(0, "t5_drain", 3'd1, 4'd0);
    chk("t5_only4", ev_valid_a, 0);
    chk("t5_sticky", ovf_a, 1);
    ovf_clr_a = 1'b1;
    @(negedge clk);
    ovf_clr_a = 1'b0;
    chk("t5_clr", ovf_a, 0);

    // Push at full with simultaneous pop is accepted
    repeat (4) send(0, 8'h51);
    ev_ready_a = 1'b1;
    send(0, 8'h44);
    ev_ready_a = 1'b0;
    chk("t5_nodrop", ovf_a, 0);
    for (int i = 0; i < 3; i++) pop_chk(0, "t5_q", 3'd1, 4'd0);
    pop_chk(0, "t5_d", 3'd2, 4'd0);
    chk("t5_empty2", ev_valid_a, 0);

    // Drop and ovf_clr in the same cycle: set wins
    repeat (4) send(0, 8'h51);
    ovf_clr_a = 1'b1;
    send(0, 8'h44);
    ovf_clr_a = 1'b0;
    chk("t5_setwins", ovf_a, 1);
    for (int i = 0; i < 4; i++) pop_chk(0, "t5_drain3", 3'd1, 4'd0);

    // MAX_ITEM=12, CASE_FOLD=0 instance
    send(1, 8'h31);
    send(1, 8'h32);
    chk("t3_pend12",  item_pend_b, 12);
    chk("t3_entry12", entry_act_b, 1);
    send(1, 8'h53);
    pop_chk(1, "t3_sel12", 3'd3, 4'd12);
    send(1, 8'h31);
    send(1, 8'h33);
    chk("t3_13_idle", entry_act_b, 0);
    chk("t3_13_pend", item_pend_b, 0);
    pop_chk(1, "t3_err13", 3'd5, 4'd0);
    send(1, 8'h73);
    chk("t3_lc_dout", dout_b, 8'h73);
    pop_chk(1, "t3_nofold", 3'd5, 4'd0);
    chk("t3_empty", ev_valid_b, 0);
    chk("t3_ovf", ovf_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
